hidden_neuron_mac: RTL

- Parametrised, time-multiplexed successor to the combinational hidden-layer neuron.
- Takes N_IN unsigned activations, N_IN signed weights and a signed bias, and accumulates them serially on one multiplier.
- Applies an arithmetic right shift, then a ReLU clamp to an unsigned OUT_W result.
- Presents the result on a valid/ready output handshake to the next layer's input buffer.

---
 rtl/hidden_neuron_mac.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hidden_neuron_mac.sv
// hidden_neuron_mac
// Time-multiplexed hidden-layer neuron. On start, it captures N_IN unsigned
// activations, N_IN signed weights and a signed bias. It then accumulates
// bias + sum(in[i] * w[i]) on a single multiplier, one term per cycle.
// The sum is arithmetic-shifted right by SHIFT and ReLU-clamped into an
// unsigned OUT_W result, which is offered on a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   start      evaluate request, only honoured in IDLE
//   in_val     packed unsigned activations, element i at [i*IN_W +: IN_W]
//   weight     packed signed weights, element i at [i*W_W +: W_W]
//   bias       signed bias
//   busy       high while accumulating (MAC) or activating (ACT)
//   out_valid  result available (HOLD)
//   out_ready  downstream accepts the result
//   out_val    activated result, kept until the next activation
//   out_sat    result clipped at 2^OUT_W-1
module hidden_neuron_mac #(
  parameter int N_IN  = 10,
  parameter int IN_W  = 10,
  parameter int W_W   = 10,
  parameter int B_W   = 16,
  parameter int ACC_W = 26,
  parameter int SHIFT = 0,
  parameter int OUT_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_IN*IN_W-1:0]   in_val,
  input  logic [N_IN*W_W-1:0]    weight,
  input  logic signed [B_W-1:0]  bias,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_val,
  output logic                   out_sat
);

  localparam int PROD_W = IN_W + W_W + 1;
  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [N_IN*IN_W-1:0]    in_snap_q, in_snap_d;
  logic [N_IN*W_W-1:0]     w_snap_q, w_snap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        out_val_q, out_val_d;
  logic                    out_sat_q, out_sat_d;

  // Unpacked views of the captured operands so the MAC can index by idx_q.
  logic [IN_W-1:0]         in_arr [N_IN];
  logic [W_W-1:0]          w_arr  [N_IN];

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
      assign in_arr[gi] = in_snap_q[gi*IN_W +: IN_W];
      assign w_arr[gi]  = w_snap_q[gi*W_W +: W_W];
    end
  endgenerate

  logic [IN_W-1:0]          in_sel;
  logic [W_W-1:0]           w_sel;
  logic signed [PROD_W-1:0] in_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, shifted;
  logic                     shifted_over;

  always_comb begin
    in_sel   = in_arr[idx_q];
    w_sel    = w_arr[idx_q];
    // Activation is zero-extended and weight sign-extended to the full
    // product width, so one signed multiply covers the mixed-sign case.
    in_ext   = $signed({{(W_W + 1){1'b0}}, in_sel});
    w_ext    = $signed({{(IN_W + 1){w_sel[W_W-1]}}, w_sel});
    prod     = in_ext * w_ext;
    prod_ext = $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    bias_ext = $signed({{(ACC_W - B_W){bias[B_W-1]}}, bias});
    shifted  = acc_q >>> SHIFT;
    // For a non-negative value, any set bit above OUT_W-1 means it exceeds
    // 2^OUT_W-1.
    shifted_over = |shifted[ACC_W-2:OUT_W];
  end

  always_comb begin
    state_d   = state_q;
    in_snap_d = in_snap_q;
    w_snap_d  = w_snap_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    out_val_d = out_val_q;
    out_sat_d = out_sat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_snap_d = in_val;
          w_snap_d  = weight;
          acc_d     = bias_ext;
          idx_d     = '0;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_ACT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_ACT: begin
        if (shifted[ACC_W-1]) begin
          out_val_d = '0;
          out_sat_d = 1'b0;
        end else if (shifted_over) begin
          out_val_d = '1;
          out_sat_d = 1'b1;
        end else begin
          out_val_d = shifted[OUT_W-1:0];
          out_sat_d = 1'b0;
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_snap_q <= '0;
      w_snap_q  <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      out_val_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_snap_q <= in_snap_d;
      w_snap_q  <= w_snap_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      out_val_q <= out_val_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign busy      = (state_q == S_MAC) || (state_q == S_ACT);
  assign out_valid = (state_q == S_HOLD);
  assign out_val   = out_val_q;
  assign out_sat   = out_sat_q;

endmodule
